// File: rtl/mem_write_checker.sv
// Self-check monitor for a data-memory write port: matches an ordered table of
// expected writes, skips an optional ignore window, and reports a registered verdict.
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         cfg_we,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] cfg_idx,
    input  logic [WIDTH-1:0]                             cfg_addr,
    input  logic [WIDTH-1:0]                             cfg_data,
    input  logic [$clog2(DEPTH+1)-1:0]                   cfg_count,
    input  logic                                         ign_en,
    input  logic [WIDTH-1:0]                             ign_lo,
    input  logic [WIDTH-1:0]                             ign_hi,
    input  logic                                         start,
    input  logic                                         MemWrite,
    input  logic [WIDTH-1:0]                             DataAdr,
    input  logic [WIDTH-1:0]                             WriteData,
    output logic                                         done,
    output logic                                         pass,
    output logic                                         fail,
    output logic [1:0]                                   fail_code,
    output logic [$clog2(DEPTH+1)-1:0]                   match_count,
    output logic [WIDTH-1:0]                             err_addr,
    output logic [WIDTH-1:0]                             err_data,
    output logic [$clog2(TIMEOUT+1)-1:0]                 cycle_count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT+1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd2;

    logic [WIDTH-1:0] exp_addr [DEPTH];
    logic [WIDTH-1:0] exp_data [DEPTH];

    logic [1:0]       state;
    logic [IW-1:0]    ptr;
    logic [CW-1:0]    cnt_q;
    logic             ign_en_q;
    logic [WIDTH-1:0] ign_lo_q;
    logic [WIDTH-1:0] ign_hi_q;

    logic             hit;
    logic             last_hit;
    logic             in_win;
    logic             tmo_edge;
    logic [CW-1:0]    cnt_clamped;
    logic [TW-1:0]    cyc_next;

    // Table survives reset; updates are only blocked while a check is running.
    always_ff @(posedge clk) begin
        if (cfg_we && state != S_RUN) begin
            exp_addr[cfg_idx] <= cfg_addr;
            exp_data[cfg_idx] <= cfg_data;
        end
    end

    always_comb begin
        hit         = MemWrite && (DataAdr == exp_addr[ptr]) && (WriteData == exp_data[ptr]);
        last_hit    = hit && ((match_count + CW'(1)) == cnt_q);
        in_win      = ign_en_q && (DataAdr >= ign_lo_q) && (DataAdr <= ign_hi_q);
        tmo_edge    = (cycle_count == TW'(TIMEOUT - 1));
        cnt_clamped = (cfg_count > CW'(DEPTH)) ? CW'(DEPTH) : cfg_count;
        cyc_next    = (cycle_count == TW'(TIMEOUT)) ? cycle_count : cycle_count + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= '0;
            match_count <= '0;
            cycle_count <= '0;
            err_addr    <= '0;
            err_data    <= '0;
            ptr         <= '0;
            cnt_q       <= '0;
            ign_en_q    <= 1'b0;
            ign_lo_q    <= '0;
            ign_hi_q    <= '0;
        end else if (start) begin
            state       <= (cnt_clamped == '0) ? S_PASS : S_RUN;
            done        <= (cnt_clamped == '0);
            pass        <= (cnt_clamped == '0);
            fail        <= 1'b0;
            fail_code   <= '0;
            match_count <= '0;
            cycle_count <= '0;
            err_addr    <= '0;
            err_data    <= '0;
            ptr         <= '0;
            cnt_q       <= cnt_clamped;
            ign_en_q    <= ign_en;
            ign_lo_q    <= ign_lo;
            ign_hi_q    <= ign_hi;
        end else if (state == S_RUN) begin
            cycle_count <= cyc_next;
            // A completing match on the last allowed edge wins over the timeout;
            // matches and ignored writes that do not complete still time out.
            if (hit) begin
                match_count <= match_count + CW'(1);
                ptr         <= ptr + IW'(1);
                if (last_hit) begin
                    state <= S_PASS;
                    done  <= 1'b1;
                    pass  <= 1'b1;
                end else if (tmo_edge) begin
                    state     <= S_FAIL;
                    done      <= 1'b1;
                    fail      <= 1'b1;
                    fail_code <= CODE_TIMEOUT;
                end
            end else if (MemWrite && !in_win) begin
                state     <= S_FAIL;
                done      <= 1'b1;
                fail      <= 1'b1;
                fail_code <= CODE_MISMATCH;
                err_addr  <= DataAdr;
                err_data  <= WriteData;
            end else if (tmo_edge) begin
                state     <= S_FAIL;
                done      <= 1'b1;
                fail      <= 1'b1;
                fail_code <= CODE_TIMEOUT;
            end
        end
    end

endmodule
